// File: rtl/lookahead_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lookahead_accumulator_pkg
// Description : Shared adder width and FSM state encoding for the accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package lookahead_accumulator_pkg;

   localparam int ADD_WIDTH = 16;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

endpackage : lookahead_accumulator_pkg
`default_nettype wire

// File: rtl/lookahead_accumulator_lookahead.sv
`default_nettype none
// ============================================================================
// Module      : Lookahead
// Description : 16-bit two-level carry-lookahead adder, carry-in tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module Lookahead
   import lookahead_accumulator_pkg::*;
(
   input  logic [ADD_WIDTH-1:0] operand1,
   input  logic [ADD_WIDTH-1:0] operand2,
   output logic [ADD_WIDTH-1:0] Result,
   output logic                 Cout
);

   logic [ADD_WIDTH-1:0] w_g;
   logic [ADD_WIDTH-1:0] w_p;
   logic [ADD_WIDTH:0]   w_c;
   logic [3:0]           w_gg;
   logic [3:0]           w_gp;
   logic [4:0]           w_bc;
   logic                 w_cin;

   assign w_cin = 1'b0;
   assign w_g   = operand1 & operand2;
   assign w_p   = operand1 ^ operand2;

   // Block carries are expanded from w_cin directly so no bit of w_bc feeds another.
   assign w_bc[0] = w_cin;
   assign w_bc[1] = w_gg[0] | (w_gp[0] & w_cin);
   assign w_bc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & w_cin);
   assign w_bc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                  | (w_gp[2] & w_gp[1] & w_gp[0] & w_cin);
   assign w_bc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                  | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                  | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & w_cin);

   genvar b;
   generate
      for (b = 0; b < 4; b++) begin : g_blk
         localparam int L = 4 * b;
         assign w_c[L]   = w_bc[b];
         assign w_c[L+1] = w_g[L] | (w_p[L] & w_bc[b]);
         assign w_c[L+2] = w_g[L+1] | (w_p[L+1] & w_g[L]) | (w_p[L+1] & w_p[L] & w_bc[b]);
         assign w_c[L+3] = w_g[L+2] | (w_p[L+2] & w_g[L+1]) | (w_p[L+2] & w_p[L+1] & w_g[L])
                         | (w_p[L+2] & w_p[L+1] & w_p[L] & w_bc[b]);
         assign w_gg[b]  = w_g[L+3] | (w_p[L+3] & w_g[L+2]) | (w_p[L+3] & w_p[L+2] & w_g[L+1])
                         | (w_p[L+3] & w_p[L+2] & w_p[L+1] & w_g[L]);
         assign w_gp[b]  = &w_p[L+3:L];
      end
   endgenerate

   assign w_c[ADD_WIDTH] = w_bc[4];
   assign Result         = w_p ^ w_c[ADD_WIDTH-1:0];
   assign Cout           = w_c[ADD_WIDTH];

endmodule : Lookahead
`default_nettype wire

// File: rtl/lookahead_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : lookahead_accumulator
// Description : Frame accumulator around the Lookahead adder with carry count.
// Revision    : 1.0 - initial release
// ============================================================================
module lookahead_accumulator
   import lookahead_accumulator_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int N_SAMPLES = 8,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic [CNT_W-1:0] out_carries
);

   generate
      if (WIDTH != ADD_WIDTH) begin : g_width_err
         $error("lookahead_accumulator: WIDTH must equal 16");
      end
      if ((N_SAMPLES < 2) || (N_SAMPLES > (2 ** CNT_W) - 1)) begin : g_nsamp_err
         $error("lookahead_accumulator: N_SAMPLES out of range");
      end
   endgenerate

   state_t           r_state;
   logic [WIDTH-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_carries;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_sum;
   logic [CNT_W-1:0] r_out_carries;

   logic [WIDTH-1:0] w_result;
   logic             w_cout;
   logic             w_accept;
   logic             w_last;
   logic [CNT_W-1:0] w_carries_nxt;

   Lookahead u_adder (
      .operand1 (r_acc),
      .operand2 (in_data),
      .Result   (w_result),
      .Cout     (w_cout)
   );

   assign in_ready      = (r_state == ST_ACCUM) && !clear && !rst;
   assign w_accept      = in_valid && in_ready;
   assign w_last        = (r_cnt == CNT_W'(N_SAMPLES - 1));
   assign w_carries_nxt = r_carries + {{(CNT_W-1){1'b0}}, w_cout};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_ACCUM;
         r_acc         <= '0;
         r_cnt         <= '0;
         r_carries     <= '0;
         r_out_valid   <= 1'b0;
         r_out_sum     <= '0;
         r_out_carries <= '0;
      end else if (clear) begin
         r_state       <= ST_ACCUM;
         r_acc         <= '0;
         r_cnt         <= '0;
         r_carries     <= '0;
         r_out_valid   <= 1'b0;
         r_out_sum     <= '0;
         r_out_carries <= '0;
      end else begin
         case (r_state)
            ST_ACCUM: begin
               if (w_accept) begin
                  r_acc     <= w_result;
                  r_carries <= w_carries_nxt;
                  r_cnt     <= r_cnt + 1'b1;
                  if (w_last) begin
                     r_out_sum     <= w_result;
                     r_out_carries <= w_carries_nxt;
                     r_out_valid   <= 1'b1;
                     r_state       <= ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (r_out_valid && out_ready) begin
                  r_acc       <= '0;
                  r_cnt       <= '0;
                  r_carries   <= '0;
                  r_out_valid <= 1'b0;
                  r_state     <= ST_ACCUM;
               end
            end
            default: r_state <= ST_ACCUM;
         endcase
      end
   end

   assign out_valid   = r_out_valid;
   assign out_sum     = r_out_sum;
   assign out_carries = r_out_carries;

endmodule : lookahead_accumulator
`default_nettype wire

// File: tb/tb_lookahead_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_lookahead_accumulator
// Description : Scoreboard bench for lookahead_accumulator with N_SAMPLES = 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lookahead_accumulator;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_sum;
   logic [7:0]  out_carries;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] sum;
      logic [7:0]  car;
   } exp_t;

   exp_t sb[$];

   lookahead_accumulator #(
      .WIDTH     (16),
      .N_SAMPLES (4),
      .CNT_W     (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .clear       (clear),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_sum     (out_sum),
      .out_carries (out_carries)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [15:0] s, input logic [7:0] c);
      exp_t e;
      e.sum = s;
      e.car = c;
      sb.push_back(e);
   endtask

   // Offer one sample and return one step after the edge that accepts it.
   task automatic send(input logic [15:0] d);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (n >= 100) begin
         chk("send_timeout", 32'(in_ready), 32'd1);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare each completed output handshake against the scoreboard.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", 32'(out_sum), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("frame_sum", 32'(out_sum), 32'(e.sum));
            chk("frame_carries", 32'(out_carries), 32'(e.car));
         end
      end
   end

   initial begin
      // Power-on reset with a sample offered.
      in_valid = 1'b1;
      in_data  = 16'h1234;
      repeat (2) step();
      chk("por_out_valid", 32'(out_valid), 32'd0);
      chk("por_in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      rst      = 1'b0;
      @(negedge clk);
      chk("por_release_in_ready", 32'(in_ready), 32'd1);
      step();

      // Basic frame with immediate handshake.
      push(16'h000A, 8'd0);
      send(16'h0001);
      send(16'h0002);
      send(16'h0003);
      send(16'h0004);
      chk("latency_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      step();
      chk("handshake_done", 32'(out_valid), 32'd0);

      // Wraparound: FFFF, FFFE, 0000, 0001 with two carries.
      push(16'h0001, 8'd2);
      send(16'hFFFF);
      send(16'hFFFF);
      send(16'h0002);
      send(16'h0001);
      step();

      // Backpressure: result held, no samples absorbed.
      out_ready = 1'b0;
      send(16'h0005);
      send(16'h0006);
      send(16'h0007);
      send(16'h0008);
      in_valid = 1'b1;
      in_data  = 16'hFFFF;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_out_sum", 32'(out_sum), 32'h001A);
      end
      step();
      in_valid = 1'b0;
      push(16'h001A, 8'd0);
      out_ready = 1'b1;
      step();
      push(16'h0400, 8'd0);
      send(16'h0100);
      send(16'h0100);
      send(16'h0100);
      send(16'h0100);
      step();

      // Clear drops a partial frame; the sample alongside it is not taken.
      send(16'h0010);
      send(16'h0020);
      in_valid = 1'b1;
      in_data  = 16'h0040;
      clear    = 1'b1;
      @(negedge clk);
      chk("clear_in_ready", 32'(in_ready), 32'd0);
      step();
      clear    = 1'b0;
      in_valid = 1'b0;
      push(16'h0004, 8'd0);
      for (int i = 0; i < 4; i++) send(16'h0001);
      step();

      // Mid-frame reset with a sample offered.
      send(16'h0033);
      send(16'h0044);
      rst      = 1'b1;
      in_valid = 1'b1;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_sum", 32'(out_sum), 32'h0000);
      chk("rst_out_carries", 32'(out_carries), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      step();
      in_valid = 1'b0;
      rst      = 1'b0;
      @(negedge clk);
      chk("rst_release_in_ready", 32'(in_ready), 32'd1);
      step();

      // Async reset while holding a result.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(16'h0003);
      #2;
      chk("hold_before_rst", 32'(out_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("async_rst_out_valid", 32'(out_valid), 32'd0);
      step();
      rst       = 1'b0;
      out_ready = 1'b1;
      step();
      push(16'h0000, 8'd1);
      for (int i = 0; i < 4; i++) send(16'h4000);

      // Drain the scoreboard within a bounded window.
      for (int i = 0; i < 50 && sb.size() != 0; i++) step();
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_lookahead_accumulator
`default_nettype wire
